// File: rtl/spi_ctrl.sv
// spi_ctrl: mode-0 SPI sequencing controller for the 16-bit shift datapath.
// Optional sticky irq output when SPI_CTRL_IRQ_EN is defined.
`timescale 1ns/1ps

module spi_ctrl #(
    parameter int WIDTH  = 16,
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_wr,
    input  logic cpu_rd,
    output logic busy,
    output logic rx_valid,
    output logic sclk,
    output logic cs_n,
    output logic we,
    output logic oe,
    output logic i_load,
    output logic i_en,
    output logic done,
    output logic tbuf_mosi_oe
`ifdef SPI_CTRL_IRQ_EN
    ,
    output logic irq
`endif
);

    localparam int DW = $clog2(CLKDIV);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT_HI,
        SHIFT_LO,
        TRAIL,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nx;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nx;
    logic          div_end;
    logic          frame_nx;

    assign div_end = (div_cnt == DW'(CLKDIV - 1));

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        we       = 1'b0;
        i_load   = 1'b0;
        oe       = cpu_rd;
        i_en     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                div_nx = '0;
                bit_nx = '0;
                // A write wins over a same-cycle read to avoid bus contention
                if (cpu_wr) begin
                    we       = 1'b1;
                    i_load   = 1'b1;
                    oe       = 1'b0;
                    state_nx = LEAD;
                end
            end
            LEAD: begin
                div_nx = div_cnt + 1'b1;
                if (div_end) begin
                    div_nx   = '0;
                    state_nx = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                i_en   = (div_cnt == '0);
                div_nx = div_cnt + 1'b1;
                if (div_end) begin
                    div_nx   = '0;
                    state_nx = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                div_nx = div_cnt + 1'b1;
                if (div_end) begin
                    div_nx = '0;
                    bit_nx = bit_cnt + 1'b1;
                    if (bit_cnt < BW'(WIDTH - 1))
                        state_nx = SHIFT_HI;
                    else
                        state_nx = TRAIL;
                end
            end
            TRAIL: begin
                div_nx = div_cnt + 1'b1;
                if (div_end) begin
                    div_nx   = '0;
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                div_nx   = '0;
                bit_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                div_nx   = '0;
                bit_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    assign frame_nx = (state_nx == LEAD) || (state_nx == SHIFT_HI)
                   || (state_nx == SHIFT_LO) || (state_nx == TRAIL);

    // Pins are registered from the next state so they line up with state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            rx_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            bit_cnt <= bit_nx;
            sclk    <= (state_nx == SHIFT_HI);
            cs_n    <= !frame_nx;
            if (done)
                rx_valid <= 1'b1;
            else if (oe)
                rx_valid <= 1'b0;
        end
    end

`ifdef SPI_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            irq <= 1'b0;
        else if (done)
            irq <= 1'b1;
        else if (oe)
            irq <= 1'b0;
    end
`endif

    assign busy         = (state != IDLE);
    assign tbuf_mosi_oe = !cs_n;

endmodule

// File: tb/tb_spi_ctrl.sv
// tb_spi_ctrl: directed bench for spi_ctrl with a small datapath/slave model.
// Covers the default build and SPI_CTRL_IRQ_EN when defined.
`timescale 1ns/1ps

module tb_spi_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
    logic busy0, rxv0, sclk0, csn0, we0, oe0, ld0, en0, done0, tb0;
    logic busy1, rxv1, sclk1, csn1, we1, oe1, ld1, en1, done1, tb1;
`ifdef SPI_CTRL_IRQ_EN
    logic irq0, irq1;
`endif

    int checks = 0;
    int errors = 0;

    spi_ctrl u0 (
        .clk(clk), .rst(rst), .cpu_wr(wr0), .cpu_rd(rd0),
        .busy(busy0), .rx_valid(rxv0), .sclk(sclk0), .cs_n(csn0),
        .we(we0), .oe(oe0), .i_load(ld0), .i_en(en0), .done(done0),
        .tbuf_mosi_oe(tb0)
`ifdef SPI_CTRL_IRQ_EN
        , .irq(irq0)
`endif
    );

    spi_ctrl #(.WIDTH(8), .CLKDIV(2)) u1 (
        .clk(clk), .rst(rst), .cpu_wr(wr1), .cpu_rd(rd1),
        .busy(busy1), .rx_valid(rxv1), .sclk(sclk1), .cs_n(csn1),
        .we(we1), .oe(oe1), .i_load(ld1), .i_en(en1), .done(done1),
        .tbuf_mosi_oe(tb1)
`ifdef SPI_CTRL_IRQ_EN
        , .irq(irq1)
`endif
    );

    // Datapath and mode-0 slave model driven by u0's strobes
    logic [15:0] tx_word = '0, slv_word = '0;
    logic [15:0] sreg = '0, rxbuf = '0, mosi_rx = '0;
    logic        mosi_q = 1'b0, sclk_d = 1'b0, miso;
    logic [4:0]  nfall = '0;

    assign miso = (nfall < 5'd16) ? slv_word[4'(5'd15 - nfall)] : 1'b0;

    always @(posedge clk) begin
        if (we0 && ld0)
            sreg <= tx_word;
        else if (en0)
            sreg <= {sreg[14:0], miso};
        mosi_q <= sreg[15];
        if (done0)
            rxbuf <= sreg;
        sclk_d <= sclk0;
        if (csn0)
            nfall <= '0;
        else if (sclk_d && !sclk0)
            nfall <= nfall + 5'd1;
        if (!sclk_d && sclk0)
            mosi_rx <= {mosi_rx[14:0], mosi_q};
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({csn0, sclk0, busy0, rxv0, we0, oe0, ld0, en0, done0, tb0}
            !== 10'b1000000000) begin
            errors++;
            $display("FAIL reset_u0: got %b expected 1000000000",
                     {csn0, sclk0, busy0, rxv0, we0, oe0, ld0, en0, done0, tb0});
        end
        checks++;
        if ({csn1, sclk1, busy1, rxv1, we1, oe1, ld1, en1, done1, tb1}
            !== 10'b1000000000) begin
            errors++;
            $display("FAIL reset_u1: got %b expected 1000000000",
                     {csn1, sclk1, busy1, rxv1, we1, oe1, ld1, en1, done1, tb1});
        end
`ifdef SPI_CTRL_IRQ_EN
        checks++;
        if ({irq0, irq1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 00", {irq0, irq1});
        end
`endif
    endtask

    task automatic test_transfer();
        int n_en = 0, bad_en = 0, n_rise = 0, n_done = 0;
        logic prev = 1'b0;
        tx_word  = 16'hA55A;
        slv_word = 16'h3C96;
        @(negedge clk);
        wr0 = 1'b1;
        #1;
        checks++;
        if ({we0, ld0, busy0} !== 3'b110) begin
            errors++;
            $display("FAIL xfer_start: got %b expected 110", {we0, ld0, busy0});
        end
        @(negedge clk);
        wr0 = 1'b0;
        for (int c = 1; c <= 138; c++) begin
            if (en0) begin
                if (c != 5 + 8 * n_en) bad_en++;
                n_en++;
            end
            if (sclk0 && !prev) n_rise++;
            prev = sclk0;
            if (done0) n_done++;
            if (c == 1) begin
                checks++;
                if ({busy0, csn0, tb0} !== 3'b101) begin
                    errors++;
                    $display("FAIL xfer_c1: got %b expected 101", {busy0, csn0, tb0});
                end
            end
            if (c == 4 || c == 5) begin
                checks++;
                if (sclk0 !== (c == 5)) begin
                    errors++;
                    $display("FAIL xfer_first_rise c%0d: got %b expected %b",
                             c, sclk0, (c == 5));
                end
            end
            if (c == 137) begin
                checks++;
                if ({done0, csn0, busy0, rxv0} !== 4'b1110) begin
                    errors++;
                    $display("FAIL xfer_c137: got %b expected 1110",
                             {done0, csn0, busy0, rxv0});
                end
            end
            if (c == 138) begin
                checks++;
                if ({done0, busy0, rxv0} !== 3'b001) begin
                    errors++;
                    $display("FAIL xfer_c138: got %b expected 001", {done0, busy0, rxv0});
                end
`ifdef SPI_CTRL_IRQ_EN
                checks++;
                if (irq0 !== 1'b1) begin
                    errors++;
                    $display("FAIL irq_rise: got %b expected 1", irq0);
                end
`endif
            end
            @(negedge clk);
        end
        checks++;
        if (n_en != 16 || bad_en != 0) begin
            errors++;
            $display("FAIL xfer_i_en: got %0d pulses %0d misplaced expected 16 0",
                     n_en, bad_en);
        end
        checks++;
        if (n_rise != 16 || n_done != 1) begin
            errors++;
            $display("FAIL xfer_counts: got rises %0d done %0d expected 16 1",
                     n_rise, n_done);
        end
        checks++;
        if (mosi_rx !== 16'hA55A) begin
            errors++;
            $display("FAIL xfer_mosi: got %h expected a55a", mosi_rx);
        end
        rd0 = 1'b1;
        #1;
        checks++;
        if (oe0 !== 1'b1 || rxbuf !== 16'h3C96) begin
            errors++;
            $display("FAIL xfer_read: got oe %b data %h expected 1 3c96", oe0, rxbuf);
        end
        @(negedge clk);
        rd0 = 1'b0;
        checks++;
        if (rxv0 !== 1'b0) begin
            errors++;
            $display("FAIL xfer_rxv_clear: got %b expected 0", rxv0);
        end
`ifdef SPI_CTRL_IRQ_EN
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b expected 0", irq0);
        end
`endif
    endtask

    task automatic test_ignore_wr();
        int n_done = 0, done_c = 0;
        tx_word  = 16'h1234;
        slv_word = 16'h0F0F;
        @(negedge clk);
        wr0 = 1'b1;
        @(negedge clk);
        tx_word = 16'hFFFF;
        for (int c = 1; c <= 138; c++) begin
            wr0 = (c == 10 || c == 60);
            #1;
            if (wr0) begin
                checks++;
                if ({we0, ld0, busy0} !== 3'b001) begin
                    errors++;
                    $display("FAIL ignore_wr c%0d: got %b expected 001",
                             c, {we0, ld0, busy0});
                end
            end
            if (done0) begin
                n_done++;
                done_c = c;
            end
            @(negedge clk);
        end
        wr0 = 1'b0;
        checks++;
        if (n_done != 1 || done_c != 137) begin
            errors++;
            $display("FAIL ignore_done: got %0d at %0d expected 1 at 137", n_done, done_c);
        end
        checks++;
        if (mosi_rx !== 16'h1234) begin
            errors++;
            $display("FAIL ignore_mosi: got %h expected 1234", mosi_rx);
        end
    endtask

    task automatic test_wr_rd_same();
        tx_word  = 16'hC3C3;
        slv_word = 16'hBEEF;
        @(negedge clk);
        wr0 = 1'b1;
        rd0 = 1'b1;
        #1;
        checks++;
        if ({oe0, we0, ld0} !== 3'b011) begin
            errors++;
            $display("FAIL wrrd_oe: got %b expected 011", {oe0, we0, ld0});
        end
        @(negedge clk);
        wr0 = 1'b0;
        rd0 = 1'b0;
        checks++;
        if ({rxv0, busy0} !== 2'b11) begin
            errors++;
            $display("FAIL wrrd_rxv: got %b expected 11", {rxv0, busy0});
        end
        repeat (136) @(negedge clk);
        rd0 = 1'b1;
        #1;
        checks++;
        if ({done0, oe0} !== 2'b11 || rxbuf !== 16'h0F0F) begin
            errors++;
            $display("FAIL rd_on_done: got %b data %h expected 11 0f0f",
                     {done0, oe0}, rxbuf);
        end
        @(negedge clk);
        rd0 = 1'b0;
        checks++;
        if (rxv0 !== 1'b1 || rxbuf !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_on_done_after: got %b data %h expected 1 beef", rxv0, rxbuf);
        end
        rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        checks++;
        if (rxv0 !== 1'b0) begin
            errors++;
            $display("FAIL wrrd_clear: got %b expected 0", rxv0);
        end
    endtask

    task automatic test_back_to_back();
        int bad_s = 0, n_done = 0, first_done = 0, last_done = 0;
        logic exp_s;
        @(negedge clk);
        wr1 = 1'b1;
        @(negedge clk);
        wr1 = 1'b0;
        for (int c = 1; c <= 76; c++) begin
            exp_s = (c >= 3 && c <= 34 && ((c - 3) % 4) < 2)
                 || (c >= 41 && c <= 72 && ((c - 41) % 4) < 2);
            if (sclk1 !== exp_s) bad_s++;
            if (done1) begin
                n_done++;
                if (first_done == 0) first_done = c;
                last_done = c;
            end
            if (c == 38) begin
                wr1 = 1'b1;
                #1;
                checks++;
                if ({we1, ld1, busy1} !== 3'b110) begin
                    errors++;
                    $display("FAIL b2b_accept: got %b expected 110", {we1, ld1, busy1});
                end
            end
            if (c == 39) begin
                wr1 = 1'b0;
                checks++;
                if ({busy1, csn1} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_start: got %b expected 10", {busy1, csn1});
                end
            end
            @(negedge clk);
        end
        checks++;
        if (bad_s != 0) begin
            errors++;
            $display("FAIL b2b_sclk: got %0d wrong cycles expected 0", bad_s);
        end
        checks++;
        if (n_done != 2 || first_done != 37 || last_done != 75) begin
            errors++;
            $display("FAIL b2b_done: got %0d at %0d,%0d expected 2 at 37,75",
                     n_done, first_done, last_done);
        end
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        tx_word  = 16'hFFFF;
        slv_word = 16'h0001;
        @(negedge clk);
        wr0 = 1'b1;
        @(negedge clk);
        wr0 = 1'b0;
        repeat (49) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({csn0, sclk0, busy0, rxv0, we0, oe0, ld0, en0, done0, tb0}
            !== 10'b1000000000) begin
            errors++;
            $display("FAIL abort_async: got %b expected 1000000000",
                     {csn0, sclk0, busy0, rxv0, we0, oe0, ld0, en0, done0, tb0});
        end
        repeat (3) begin
            @(negedge clk);
            if (done0) n_done++;
        end
        rst = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (done0) n_done++;
        end
        checks++;
        if (n_done != 0 || busy0 !== 1'b0 || csn0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: got done %0d busy %b cs_n %b expected 0 0 1",
                     n_done, busy0, csn0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_transfer();
        test_ignore_wr();
        test_wr_rd_same();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
